// File: rtl/ssd_disparity_line_if.sv
// rtl/ssd_disparity_line_if.sv - pixel-pair stream in, disparity/display stream out
interface ssd_disparity_line_if #(
    parameter int MAX_DISP = 16,
    parameter int WIN      = 5
);
    localparam int DISP_W = $clog2(MAX_DISP);
    localparam int COST_W = 16 + $clog2(WIN + 1);

    logic              in_vsync;
    logic              in_hsync;
    logic [7:0]        in_pix_l;
    logic [7:0]        in_pix_r;
    logic              out_vsync;
    logic              out_hsync;
    logic [DISP_W-1:0] out_disp;
    logic [7:0]        out_pix;
    logic [COST_W-1:0] out_cost;

    modport master (
        output in_vsync, in_hsync, in_pix_l, in_pix_r,
        input  out_vsync, out_hsync, out_disp, out_pix, out_cost
    );

    modport slave (
        input  in_vsync, in_hsync, in_pix_l, in_pix_r,
        output out_vsync, out_hsync, out_disp, out_pix, out_cost
    );
endinterface

// File: rtl/ssd_disparity_line.sv
// rtl/ssd_disparity_line.sv - 4-stage streaming 1-D window stereo disparity (SSD; SAD when COST_SAD_EN)
module ssd_disparity_line #(
    parameter int WIDTH    = 640,
    parameter int MAX_DISP = 16,
    parameter int WIN      = 5
) (
    input  logic                HCLK,
    input  logic                HRESETn,
    ssd_disparity_line_if.slave bus
);
    localparam int X_W    = $clog2(WIDTH);
    localparam int DISP_W = $clog2(MAX_DISP);
    localparam int COST_W = 16 + $clog2(WIN + 1);
`ifdef COST_SAD_EN
    localparam int PC_W = 8;
`else
    localparam int PC_W = 16;
`endif
    localparam int SUM_W = PC_W + $clog2(WIN + 1);
    localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);

    logic [X_W-1:0]   r_cnt;

    logic             r_hs0, r_vs0;
    logic [X_W-1:0]   r_x0;
    logic [7:0]       r_l0, r_r0;

    logic             r_hs1, r_vs1;
    logic [X_W-1:0]   r_x1;
    logic [7:0]       r_l1;
    logic [7:0]       r_hist_r [MAX_DISP];

    logic             r_hs2, r_vs2;
    logic [X_W-1:0]   r_x2;
    logic [PC_W-1:0]  r_cost [MAX_DISP][WIN];

    logic             r_hs3, r_vs3;
    logic [X_W-1:0]   r_x3;
    logic [SUM_W-1:0] r_sum [MAX_DISP];

    logic signed [8:0] w_diff [MAX_DISP];
    logic [7:0]        w_mag  [MAX_DISP];
    logic [PC_W-1:0]   w_pc   [MAX_DISP];
    logic [SUM_W-1:0]  w_sum  [MAX_DISP];
    logic [SUM_W-1:0]  w_best_cost;
    logic [DISP_W-1:0] w_best_d;
    logic              w_any_valid;

    // Column tag travels with each pixel; validity is judged from it, never from buffer contents
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_cnt <= '0;
        end else if (bus.in_hsync) begin
            if (r_cnt != X_LAST) r_cnt <= r_cnt + X_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_hs0 <= 1'b0;
            r_vs0 <= 1'b0;
            r_x0  <= '0;
            r_l0  <= '0;
            r_r0  <= '0;
            r_hs1 <= 1'b0;
            r_vs1 <= 1'b0;
            r_x1  <= '0;
            r_l1  <= '0;
            for (int d = 0; d < MAX_DISP; d++) r_hist_r[d] <= '0;
        end else begin
            r_hs0 <= bus.in_hsync;
            r_vs0 <= bus.in_vsync;
            r_x0  <= r_cnt;
            r_l0  <= bus.in_pix_l;
            r_r0  <= bus.in_pix_r;
            r_hs1 <= r_hs0;
            r_vs1 <= r_vs0;
            r_x1  <= r_x0;
            if (r_hs0) begin
                r_l1        <= r_l0;
                r_hist_r[0] <= r_r0;
                for (int d = 1; d < MAX_DISP; d++) r_hist_r[d] <= r_hist_r[d-1];
            end
        end
    end

    // Costs of earlier columns are kept per candidate, so only MAX_DISP differences are formed per pixel
    always_comb begin
        for (int d = 0; d < MAX_DISP; d++) begin
            w_diff[d] = $signed({1'b0, r_l1}) - $signed({1'b0, r_hist_r[d]});
            w_mag[d]  = w_diff[d][8] ? 8'(-w_diff[d]) : w_diff[d][7:0];
`ifdef COST_SAD_EN
            w_pc[d]   = w_mag[d];
`else
            w_pc[d]   = 16'(w_mag[d]) * 16'(w_mag[d]);
`endif
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_hs2 <= 1'b0;
            r_vs2 <= 1'b0;
            r_x2  <= '0;
            for (int d = 0; d < MAX_DISP; d++)
                for (int k = 0; k < WIN; k++) r_cost[d][k] <= '0;
        end else begin
            r_hs2 <= r_hs1;
            r_vs2 <= r_vs1;
            r_x2  <= r_x1;
            if (r_hs1) begin
                for (int d = 0; d < MAX_DISP; d++) begin
                    r_cost[d][0] <= w_pc[d];
                    for (int k = 1; k < WIN; k++) r_cost[d][k] <= r_cost[d][k-1];
                end
            end
        end
    end

    always_comb begin
        for (int d = 0; d < MAX_DISP; d++) begin
            w_sum[d] = '0;
            for (int k = 0; k < WIN; k++) w_sum[d] = w_sum[d] + SUM_W'(r_cost[d][k]);
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_hs3 <= 1'b0;
            r_vs3 <= 1'b0;
            r_x3  <= '0;
            for (int d = 0; d < MAX_DISP; d++) r_sum[d] <= '0;
        end else begin
            r_hs3 <= r_hs2;
            r_vs3 <= r_vs2;
            r_x3  <= r_x2;
            for (int d = 0; d < MAX_DISP; d++) r_sum[d] <= w_sum[d];
        end
    end

    // Strict less-than keeps the lowest disparity on ties; d=0 is valid whenever any candidate is
    always_comb begin
        w_best_cost = r_sum[0];
        w_best_d    = '0;
        w_any_valid = (int'(r_x3) >= WIN - 1);
        for (int d = 1; d < MAX_DISP; d++) begin
            if ((int'(r_x3) >= WIN - 1 + d) && (r_sum[d] < w_best_cost)) begin
                w_best_cost = r_sum[d];
                w_best_d    = DISP_W'(d);
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            bus.out_hsync <= 1'b0;
            bus.out_vsync <= 1'b0;
            bus.out_disp  <= '0;
            bus.out_pix   <= '0;
            bus.out_cost  <= '0;
        end else begin
            bus.out_hsync <= r_hs3;
            bus.out_vsync <= r_vs3;
            if (r_hs3 && w_any_valid) begin
                bus.out_disp <= w_best_d;
                bus.out_pix  <= {w_best_d, {(8 - DISP_W){1'b0}}};
                bus.out_cost <= COST_W'(w_best_cost);
            end else begin
                bus.out_disp <= '0;
                bus.out_pix  <= '0;
                bus.out_cost <= '0;
            end
        end
    end
endmodule
